// File: rtl/const_load_sequencer_pkg.sv
// Shared types and helpers for the constant-load sequencer: op and state
// encodings, extender control codes and the byte-merge rule.
`default_nettype none

package const_pkg;

  localparam int DATA_W  = 16;
  localparam int CONST_W = 11;

  typedef enum logic [1:0] {
    OP_LOADLIT = 2'b00,
    OP_LCL     = 2'b01,
    OP_LCH     = 2'b10,
    OP_ILL     = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EXT  = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_t;

  // The extender decodes the same two bits as the instruction op field.
  localparam logic [1:0] EXT_SEXT = 2'b00;
  localparam logic [1:0] EXT_LOW  = 2'b01;
  localparam logic [1:0] EXT_HIGH = 2'b10;

  function automatic logic [DATA_W-1:0] byte_merge(input op_t op,
                                                   input logic [DATA_W-1:0] ext,
                                                   input logic [DATA_W-1:0] old);
    logic [DATA_W-1:0] res;
    res = ext;
    case (op)
      OP_LCL:  res = {old[15:8], ext[7:0]};
      OP_LCH:  res = {ext[15:8], old[7:0]};
      default: res = ext;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/const_load_sequencer.sv
// Multi-cycle controller for LOADLIT/LCL/LCH: drives the constant extender,
// reads the old destination for byte merges and issues one handshaked write.
`default_nettype none

module const_load_sequencer #(
  parameter int DATA_W  = 16,
  parameter int CONST_W = 11,
  parameter int ADDR_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [CONST_W-1:0] req_const,
  input  logic [ADDR_W-1:0]  req_dest,
  output logic [1:0]         ext_ctrl,
  output logic [CONST_W-1:0] ext_const,
  input  logic [DATA_W-1:0]  ext_value,
  output logic               rf_rd_en,
  output logic [ADDR_W-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0]  rf_rd_data,
  output logic               rf_wr_en,
  input  logic               rf_wr_ready,
  output logic [ADDR_W-1:0]  rf_wr_addr,
  output logic [DATA_W-1:0]  rf_wr_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  import const_pkg::*;

  state_t              state;
  state_t              state_n;
  op_t                 op_q;
  logic [ADDR_W-1:0]   dest_q;
  logic [CONST_W-1:0]  const_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                done_q;
  logic                accept;

  assign accept = req_valid && (state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Request fields are frozen at acceptance; later changes on req_* are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q    <= OP_LOADLIT;
      dest_q  <= '0;
      const_q <= '0;
    end else if (accept) begin
      op_q    <= op_t'(req_op);
      dest_q  <= req_dest;
      const_q <= req_const;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_data_q <= '0;
    end else if (state == EXT) begin
      wr_data_q <= byte_merge(op_q, ext_value, rf_rd_data);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state == WR) && rf_wr_ready;
    end
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    ext_ctrl   = EXT_SEXT;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    busy       = 1'b1;
    err        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          case (op_t'(req_op))
            OP_LOADLIT:    state_n = EXT;
            OP_LCL, OP_LCH: state_n = RD;
            default:       state_n = ERR;
          endcase
        end
      end
      RD: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = dest_q;
        state_n    = EXT;
      end
      EXT: begin
        ext_ctrl = op_q;
        state_n  = WR;
      end
      WR: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = dest_q;
        if (rf_wr_ready) begin
          state_n = IDLE;
        end
      end
      ERR: begin
        err     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign ext_const  = const_q;
  assign rf_wr_data = wr_data_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: doc/const_load_sequencer.md
Name: const_load_sequencer

Overview:
- Multi-cycle controller that executes the constant-load instruction class (LOADLIT, LCL, LCH) using the constant extender and the register file.
- Accepts one decoded request, drives the extender control, reads the old destination value when a byte merge is needed, and issues one register-file write with a ready handshake.
- Sits between the instruction decode stage and the register-file write port.

Parameters:
- DATA_W, 16, register width; only 16 is supported.
- CONST_W, 11, width of the instruction constant field.
- ADDR_W, 4, register address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request (IDLE only).
- req_op  in  2  00 LOADLIT, 01 LCL, 10 LCH, 11 illegal.
- req_const  in  CONST_W  constant field.
- req_dest  in  ADDR_W  destination register.
- ext_ctrl  out  2  control to the constant extender.
- ext_const  out  CONST_W  constant to the extender.
- ext_value  in  DATA_W  extender output (combinational from ext_ctrl/ext_const).
- rf_rd_en  out  1  register read strobe.
- rf_rd_addr  out  ADDR_W  read address.
- rf_rd_data  in  DATA_W  read data, valid one cycle after rf_rd_en.
- rf_wr_en  out  1  write request; held until accepted.
- rf_wr_ready  in  1  register file accepts the write.
- rf_wr_addr  out  ADDR_W  write address.
- rf_wr_data  out  DATA_W  write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after a write is accepted.
- err  out  1  one-cycle pulse after an illegal op is accepted.

Behaviour:
- Reset values: state IDLE; req_ready 1; all other outputs 0, including ext_ctrl 00, ext_const 0, rf_* 0, busy, done and err.
- Reset asserted in any state returns to IDLE next edge. rf_wr_en drops, no done or err pulse, and the captured request is discarded.
- Acceptance: handshake when req_valid && req_ready. On acceptance, op/const/dest are registered, and ext_const is driven from the captured constant.
- States: IDLE, RD, EXT, WR, ERR.
  - IDLE: on accept with op 00, go to EXT. With op 01/10, go to RD. With op 11, go to ERR.
  - RD: rf_rd_en=1, rf_rd_addr=dest for exactly one cycle, then EXT.
  - EXT: ext_ctrl=op. Merge result is registered into rf_wr_data, then WR. ext_ctrl is 00 outside EXT.
    - LOADLIT: wr_data = ext_value (sign-extended 11-bit).
    - LCL: wr_data = {rf_rd_data[15:8], ext_value[7:0]}.
    - LCH: wr_data = {ext_value[15:8], rf_rd_data[7:0]}.
  - WR: rf_wr_en=1, rf_wr_addr=dest, and rf_wr_data stays stable. When rf_wr_ready=1, go to IDLE and pulse done in the next (IDLE) cycle. Stalls indefinitely while rf_wr_ready=0.
  - ERR: one cycle with err=1, no register access, then IDLE.
- Latency with rf_wr_ready tied high, measured from the accept edge:
  - LOADLIT: write accepted 2 cycles later; done 3 cycles later.
  - LCL/LCH: write accepted 3 cycles later; done 4 cycles later.
- A new request may be accepted in the same IDLE cycle that done is high; done and req_ready coexist there.
- req_op/req_const changes while busy have no effect.
- rf_rd_data is sampled only in EXT.

Decomposition:
- Shared package const_pkg holds:
  - the op enum: OP_LOADLIT=2'b00, OP_LCL=2'b01, OP_LCH=2'b10, OP_ILL=2'b11;
  - the state enum: IDLE, RD, EXT, WR, ERR;
  - DATA_W and CONST_W constants.
- The extender control encoding in the package must match the existing extender's encoding.
- Single module, no sub-modules. The byte-merge function lives in the package as a function byte_merge(op, ext, old).

Test Plan:
- LOADLIT, const=11'h7FF, dest=3, wr_ready=1 -> rf_wr_data=16'hFFFF at addr 3, done 3 cycles after accept. Repeat with const=11'h3FF -> 16'h03FF.
- LCL, const=11'h0A5, old R5=16'h1234 -> rd of addr 5 once, write 16'h12A5, done at accept+4.
- LCH, const=11'h05A, old R2=16'h1234, wr_ready low for 5 cycles -> rf_wr_en held 5 cycles with stable 16'h5A34, then write accepted, then done.
- op 11, dest=7 -> err pulse one cycle, no rf_rd_en/rf_wr_en, req_ready back 2 cycles after accept.
- reset asserted in WR with wr_ready=0 -> next cycle IDLE, rf_wr_en=0, no done; a subsequent LOADLIT completes normally.
- Back-to-back: req_valid held with LOADLIT then LCH -> second accepted in the cycle done of the first is high; both writes correct.
